// File: rtl/MIPS_pkg.sv
// Shared MIPS opcode/funct encodings plus the multi-cycle controller's state,
// ALU-control and trap-cause types and the small decode helpers used by it.
package MIPS_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B
    } mips_op_e;

    typedef enum logic [5:0] {
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } mips_funct_e;

    typedef enum logic [4:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEMADDR,
        ST_MEMREAD,
        ST_MEMWB,
        ST_MEMWRITE,
        ST_EXECUTE,
        ST_ALUWB,
        ST_BRANCH,
        ST_IEXEC,
        ST_IWB,
        ST_JUMP,
        ST_JAL,
        ST_JR,
        ST_TRAP
    } mips_ctrl_state_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_FUNCT = 3'd2,
        ALU_SLT   = 3'd3,
        ALU_SLTU  = 3'd4,
        ALU_AND   = 3'd5,
        ALU_OR    = 3'd6,
        ALU_LUI   = 3'd7
    } mips_ctrl_alu_op_e;

    typedef enum logic [1:0] {
        TC_NONE        = 2'd0,
        TC_ILLEGAL_OP  = 2'd1,
        TC_ILLEGAL_FN  = 2'd2,
        TC_MEM_TIMEOUT = 2'd3
    } mips_trap_cause_e;

    localparam logic [1:0] MEM_SIZE_WORD = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_BYTE = 2'd2;

    // Opcodes that only exist in the extended ISA mode
    function automatic logic is_ext_op(input logic [5:0] op);
        case (op)
            OP_JAL, OP_BNE, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI,
            OP_LBU, OP_LHU, OP_SB, OP_SH: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // R-type functs executed by the ALU (JR is handled separately)
    function automatic logic is_alu_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic [1:0] mem_size_of(input logic [5:0] op);
        case (op)
            OP_LHU, OP_SH: return MEM_SIZE_HALF;
            OP_LBU, OP_SB: return MEM_SIZE_BYTE;
            default:       return MEM_SIZE_WORD;
        endcase
    endfunction

    function automatic mips_ctrl_alu_op_e imm_alu_op(input logic [5:0] op);
        case (op)
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_LUI:   return ALU_LUI;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive cycles a memory request goes unanswered and flags the
// cycle in which the wait limit is hit (a same-cycle ready suppresses it).
module mips_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ready,
    output logic expire_c
);

    localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;

    // Clear outside a pending request or on completion; saturate otherwise
    always_ff @(posedge clk) begin
        if (rst || !mem_req || mem_ready) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    // Fires in the wait cycle that would bring the count to MEM_TIMEOUT
    assign expire_c = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                      (wait_cnt == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: Moore FSM driving datapath control, with
// handshaked memory, optional extended ISA, sticky trap and retire counter.
module mips_mc_ctrl_fsm
    import MIPS_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter bit          EXT_ISA     = 1'b1,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           ir_op,
    input  logic [5:0]           ir_funct,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [1:0]           mem_size,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 branch_eq,
    output logic                 branch_ne,
    output logic [1:0]           pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output mips_ctrl_alu_op_e    alu_op,
    output logic                 imm_zext,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 reg_write,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] instr_retired
);

    mips_ctrl_state_e state, state_next;
    mips_trap_cause_e cause_next;
    logic             retire_c;
    logic             expire_c;

    // Request is a pure function of state so the timer sees no loop back
    assign mem_req = !rst && ((state == ST_FETCH) || (state == ST_MEMREAD) ||
                              (state == ST_MEMWRITE));

    mips_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (mem_req),
        .mem_ready(mem_ready),
        .expire_c (expire_c)
    );

    // State, sticky trap and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FETCH;
            trap          <= 1'b0;
            trap_cause    <= 2'(TC_NONE);
            instr_retired <= '0;
        end else begin
            state <= state_next;
            if ((state_next == ST_TRAP) && (state != ST_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= 2'(cause_next);
            end
            if (retire_c) begin
                instr_retired <= instr_retired + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state and control decode; everything held low during reset
    always_comb begin
        state_next = state;
        cause_next = TC_NONE;
        retire_c   = 1'b0;
        mem_we     = 1'b0;
        mem_size   = MEM_SIZE_WORD;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        imm_zext   = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        reg_write  = 1'b0;

        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    alu_src_b = 2'd1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = ST_DECODE;
                    end else if (expire_c) begin
                        state_next = ST_TRAP;
                        cause_next = TC_MEM_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    alu_src_b = 2'd3;
                    if (!EXT_ISA && is_ext_op(ir_op)) begin
                        state_next = ST_TRAP;
                        cause_next = TC_ILLEGAL_OP;
                    end else begin
                        case (ir_op)
                            OP_LW, OP_LBU, OP_LHU,
                            OP_SW, OP_SB, OP_SH:     state_next = ST_MEMADDR;
                            OP_BEQ, OP_BNE:          state_next = ST_BRANCH;
                            OP_ADDI, OP_SLTI, OP_SLTIU,
                            OP_ANDI, OP_ORI, OP_LUI: state_next = ST_IEXEC;
                            OP_J:                    state_next = ST_JUMP;
                            OP_JAL:                  state_next = ST_JAL;
                            OP_RTYPE: begin
                                if (EXT_ISA && (ir_funct == FN_JR)) begin
                                    state_next = ST_JR;
                                end else if (is_alu_funct(ir_funct)) begin
                                    state_next = ST_EXECUTE;
                                end else begin
                                    state_next = ST_TRAP;
                                    cause_next = TC_ILLEGAL_FN;
                                end
                            end
                            default: begin
                                state_next = ST_TRAP;
                                cause_next = TC_ILLEGAL_OP;
                            end
                        endcase
                    end
                end
                ST_MEMADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    state_next = is_store(ir_op) ? ST_MEMWRITE : ST_MEMREAD;
                end
                ST_MEMREAD: begin
                    iord     = 1'b1;
                    mem_size = mem_size_of(ir_op);
                    if (mem_ready) begin
                        state_next = ST_MEMWB;
                    end else if (expire_c) begin
                        state_next = ST_TRAP;
                        cause_next = TC_MEM_TIMEOUT;
                    end
                end
                ST_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_MEMWRITE: begin
                    iord     = 1'b1;
                    mem_we   = 1'b1;
                    mem_size = mem_size_of(ir_op);
                    if (mem_ready) begin
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end else if (expire_c) begin
                        state_next = ST_TRAP;
                        cause_next = TC_MEM_TIMEOUT;
                    end
                end
                ST_EXECUTE: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_FUNCT;
                    state_next = ST_ALUWB;
                end
                ST_ALUWB: begin
                    reg_dst    = 2'd1;
                    reg_write  = 1'b1;
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_IEXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    alu_op     = imm_alu_op(ir_op);
                    imm_zext   = (ir_op == OP_ANDI) || (ir_op == OP_ORI);
                    state_next = ST_IWB;
                end
                ST_IWB: begin
                    reg_write  = 1'b1;
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = 2'd1;
                    branch_eq  = (ir_op == OP_BEQ);
                    branch_ne  = (ir_op == OP_BNE);
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_JR: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd3;
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end
                ST_TRAP: begin
                    state_next = ST_TRAP;
                end
                default: begin
                    state_next = ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl_fsm.sv
// Directed bench for the multi-cycle controller: one extended-ISA instance
// with a short memory timeout and one base-ISA instance.
module tb_mips_mc_ctrl_fsm;
    import MIPS_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  ir_op;
    logic [5:0]  ir_funct;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write;
    logic        branch_eq, branch_ne, alu_src_a, imm_zext, reg_write, trap;
    logic [1:0]  mem_size, pc_src, alu_src_b, reg_dst, mem_to_reg, trap_cause;
    logic [2:0]  alu_op;
    logic [31:0] instr_retired;

    logic        rst_b;
    logic [5:0]  ir_op_b;
    logic [5:0]  ir_funct_b;
    logic        mem_ready_b;
    logic        mem_req_b, mem_we_b, iord_b, ir_write_b, pc_write_b;
    logic        branch_eq_b, branch_ne_b, alu_src_a_b, imm_zext_b, reg_write_b, trap_b;
    logic [1:0]  mem_size_b, pc_src_b, alu_src_b_b, reg_dst_b, mem_to_reg_b, trap_cause_b;
    logic [2:0]  alu_op_b;
    logic [31:0] instr_retired_b;

    int n_vec = 0;
    int n_err = 0;
    int req_cnt;
    int rw_cnt;
    int pw_cnt;

    mips_mc_ctrl_fsm #(.MEM_TIMEOUT(4), .EXT_ISA(1'b1), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ir_op(ir_op), .ir_funct(ir_funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .imm_zext(imm_zext), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .trap(trap), .trap_cause(trap_cause), .instr_retired(instr_retired)
    );

    mips_mc_ctrl_fsm #(.MEM_TIMEOUT(255), .EXT_ISA(1'b0), .CNT_WIDTH(32)) dut_base (
        .clk(clk), .rst(rst_b), .ir_op(ir_op_b), .ir_funct(ir_funct_b), .mem_ready(mem_ready_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_size(mem_size_b), .iord(iord_b),
        .ir_write(ir_write_b), .pc_write(pc_write_b), .branch_eq(branch_eq_b),
        .branch_ne(branch_ne_b), .pc_src(pc_src_b), .alu_src_a(alu_src_a_b),
        .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .imm_zext(imm_zext_b), .reg_dst(reg_dst_b),
        .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b), .trap(trap_b),
        .trap_cause(trap_cause_b), .instr_retired(instr_retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ir_op = 6'h00; ir_funct = 6'h00; mem_ready = 1'b0;
        rst_b = 1'b1; ir_op_b = 6'h00; ir_funct_b = 6'h00; mem_ready_b = 1'b1;
        repeat (2) tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_cause", 32'(trap_cause), 32'd0);
        check("rst_retired", instr_retired, 32'd0);

        // ADDI, ready tied high: 4 cycles
        rst = 1'b0; ir_op = OP_ADDI; mem_ready = 1'b1;
        #1;
        check("fetch_mem_req", 32'(mem_req), 32'd1);
        check("fetch_ir_write", 32'(ir_write), 32'd1);
        check("fetch_pc_write", 32'(pc_write), 32'd1);
        check("fetch_alu_src_b", 32'(alu_src_b), 32'd1);
        check("fetch_iord", 32'(iord), 32'd0);
        tick();
        check("decode_alu_src_b", 32'(alu_src_b), 32'd3);
        tick();
        check("addi_alu_op", 32'(alu_op), 32'd0);
        check("addi_zext", 32'(imm_zext), 32'd0);
        tick();
        check("addi_iwb_rw", 32'(reg_write), 32'd1);
        check("addi_not_yet", instr_retired, 32'd0);
        tick();
        check("addi_4cyc", instr_retired, 32'd1);

        // J: 3 cycles
        ir_op = OP_J;
        tick();
        tick();
        check("j_pc_write", 32'(pc_write), 32'd1);
        check("j_pc_src", 32'(pc_src), 32'd2);
        check("j_not_yet", instr_retired, 32'd1);
        tick();
        check("j_3cyc", instr_retired, 32'd2);

        // LW, ready withheld 3 cycles in MEMREAD; 4th (limit) cycle ready wins
        ir_op = OP_LW; rw_cnt = 0; req_cnt = 0;
        rw_cnt += int'(reg_write); tick();
        rw_cnt += int'(reg_write); tick();
        mem_ready = 1'b0;
        rw_cnt += int'(reg_write); tick();
        check("lw_iord", 32'(iord), 32'd1);
        check("lw_size", 32'(mem_size), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            req_cnt += int'(mem_req);
            rw_cnt  += int'(reg_write);
            tick();
        end
        check("lw_req_cycles", 32'(req_cnt), 32'd4);
        check("lw_rw_early", 32'(rw_cnt), 32'd0);
        check("lw_no_trap", 32'(trap), 32'd0);
        check("lw_memwb_rw", 32'(reg_write), 32'd1);
        check("lw_memwb_m2r", 32'(mem_to_reg), 32'd1);
        check("lw_not_yet", instr_retired, 32'd2);
        tick();
        check("lw_8cyc", instr_retired, 32'd3);

        // SH: halfword store, 4 cycles
        ir_op = OP_SH;
        tick();
        tick();
        check("sh_addr_src_a", 32'(alu_src_a), 32'd1);
        check("sh_addr_src_b", 32'(alu_src_b), 32'd2);
        tick();
        check("sh_we", 32'(mem_we), 32'd1);
        check("sh_size", 32'(mem_size), 32'd1);
        tick();
        check("sh_retired", instr_retired, 32'd4);

        // LBU: byte size
        ir_op = OP_LBU;
        tick(); tick(); tick();
        check("lbu_size", 32'(mem_size), 32'd2);
        check("lbu_we", 32'(mem_we), 32'd0);
        tick(); tick();
        check("lbu_retired", instr_retired, 32'd5);

        // SW stalled, reset mid-wait
        ir_op = OP_SW;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        check("sw_wait_we", 32'(mem_we), 32'd1);
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_drops_req", 32'(mem_req), 32'd0);
        check("rst_drops_we", 32'(mem_we), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_fetch_req", 32'(mem_req), 32'd1);
        check("post_rst_iord", 32'(iord), 32'd0);
        check("post_rst_retired", instr_retired, 32'd0);

        // Fetch timeout with ready stuck low (proves the wait count restarted)
        pw_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            pw_cnt += int'(pc_write);
            tick();
        end
        check("to_not_early", 32'(trap), 32'd0);
        pw_cnt += int'(pc_write);
        tick();
        check("to_trap", 32'(trap), 32'd1);
        check("to_cause", 32'(trap_cause), 32'd3);
        check("to_req_low", 32'(mem_req), 32'd0);
        check("to_no_pc_write", 32'(pw_cnt), 32'd0);
        mem_ready = 1'b1;
        tick(); tick();
        check("trap_sticky", 32'(trap), 32'd1);
        check("trap_no_fetch", 32'(ir_write), 32'd0);

        // Illegal op and illegal funct
        do_reset();
        ir_op = 6'h3F;
        tick(); tick();
        check("illop_trap", 32'(trap), 32'd1);
        check("illop_cause", 32'(trap_cause), 32'd1);
        do_reset();
        check("rst_clears_trap", 32'(trap), 32'd0);
        ir_op = OP_RTYPE; ir_funct = 6'h3F;
        tick(); tick();
        check("illfn_cause", 32'(trap_cause), 32'd2);
        do_reset();

        // JAL
        ir_op = OP_JAL;
        tick(); tick();
        check("jal_pc_write", 32'(pc_write), 32'd1);
        check("jal_pc_src", 32'(pc_src), 32'd2);
        check("jal_reg_write", 32'(reg_write), 32'd1);
        check("jal_reg_dst", 32'(reg_dst), 32'd2);
        check("jal_m2r", 32'(mem_to_reg), 32'd2);
        tick();
        check("jal_retired", instr_retired, 32'd1);

        // JR
        ir_op = OP_RTYPE; ir_funct = FN_JR;
        tick(); tick();
        check("jr_pc_src", 32'(pc_src), 32'd3);
        check("jr_pc_write", 32'(pc_write), 32'd1);
        tick();
        check("jr_retired", instr_retired, 32'd2);

        // BNE
        ir_op = OP_BNE;
        tick(); tick();
        check("bne_ne", 32'(branch_ne), 32'd1);
        check("bne_eq", 32'(branch_eq), 32'd0);
        check("bne_alu_op", 32'(alu_op), 32'd1);
        check("bne_pc_src", 32'(pc_src), 32'd1);
        tick();

        // ORI
        ir_op = OP_ORI;
        tick(); tick();
        check("ori_zext", 32'(imm_zext), 32'd1);
        check("ori_alu_op", 32'(alu_op), 32'd6);
        tick(); tick();

        // R-type ADD
        ir_op = OP_RTYPE; ir_funct = FN_ADD;
        tick(); tick();
        check("add_alu_op", 32'(alu_op), 32'd2);
        tick();
        check("add_reg_dst", 32'(reg_dst), 32'd1);
        check("add_reg_write", 32'(reg_write), 32'd1);
        tick();
        check("final_retired", instr_retired, 32'd5);

        // Base-ISA instance: ADDI legal, JAL traps as illegal op
        rst_b = 1'b0; ir_op_b = OP_ADDI;
        repeat (4) tick();
        check("base_addi_retired", instr_retired_b, 32'd1);
        ir_op_b = OP_JAL;
        tick(); tick();
        check("base_jal_trap", 32'(trap_b), 32'd1);
        check("base_jal_cause", 32'(trap_cause_b), 32'd1);
        check("base_jal_no_pcw", 32'(pc_write_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl_fsm.md
Name: mips_mc_ctrl_fsm

Overview:
Parametrised main controller for the multi-cycle, non-pipelined MIPS core. It decodes op/funct from the instruction register and steps a Moore FSM that drives datapath control. It generalises the original 12-state controller in three ways: variable-latency memory via a req/ready handshake with timeout, an extended ISA mode (JAL, JR, LUI, ORI/ANDI/SLTI[U], sub-word loads/stores), and trap and retire reporting.

Parameters:
MEM_TIMEOUT, 255, max cycles waiting for mem_ready before bus-error trap; 0 disables the timeout.
EXT_ISA, 1, 1 = extended ops legal; 0 = only RTYPE/LW/SW/BEQ/ADDI/J legal, all other ops trap.
CNT_WIDTH, 32, width of instr_retired.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ir_op  in  6  opcode from IR (mips_op_e)
ir_funct  in  6  funct from IR (mips_funct_e)
mem_ready  in  1  memory done; sampled only while mem_req=1
mem_req  out  1  memory access request
mem_we  out  1  write qualifier, valid with mem_req
mem_size  out  2  0 word, 1 half, 2 byte
iord  out  1  0 = addr from PC, 1 = addr from ALUOut
ir_write  out  1  load IR
pc_write  out  1  unconditional PC write
branch_eq  out  1  PC write if zero
branch_ne  out  1  PC write if not zero
pc_src  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 rs
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2
alu_op  out  3  mips_ctrl_alu_op_e
imm_zext  out  1  zero-extend immediate (ANDI/ORI)
reg_dst  out  2  0 rt, 1 rd, 2 $31
mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC
reg_write  out  1  register file write
trap  out  1  sticky; core halted
trap_cause  out  2  0 none, 1 illegal op, 2 illegal funct, 3 mem timeout
instr_retired  out  CNT_WIDTH  completed-instruction count

Behaviour:
- rst high: next state FETCH, wait counter 0, trap 0, trap_cause 0, instr_retired 0. All control outputs are 0 while rst=1.
- States (5-bit enum): FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, IEXEC, IWB, JUMP, JAL, JR, TRAP.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. ir_write and pc_write assert only in the cycle mem_ready=1; that cycle also moves to DECODE. Otherwise hold.
- DECODE: ALU computes PC+(simm<<2) (alu_src_b=3, ADD). Next state by op:
  - LW/LBU/LHU/SW/SB/SH -> MEMADDR
  - RTYPE -> JR if funct=JR, EXECUTE if funct is legal, else TRAP cause 2
  - BEQ/BNE -> BRANCH
  - I-type ALU -> IEXEC
  - J -> JUMP; JAL -> JAL
  - any other op -> TRAP cause 1
  - with EXT_ISA=0, extended ops -> TRAP cause 1
- MEMADDR -> MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, iord=1. Moves to MEMWB on mem_ready.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Moves to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, iord=1. Moves to FETCH on mem_ready.
- mem_size: 1 for LHU/SH, 2 for LBU/SB, else 0; valid in MEMREAD/MEMWRITE.
- EXECUTE: alu_op=FUNCT. ALUWB: reg_dst=1, reg_write=1.
- IEXEC: alu_op=ADD/SLT/SLTU/AND/OR/LUI; imm_zext=1 for ANDI/ORI. IWB: reg_dst=0, reg_write=1.
- BRANCH: alu_op=SUB, pc_src=1; branch_eq for BEQ, branch_ne for BNE.
- JUMP: pc_write=1, pc_src=2.
- JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2 (PC already +4).
- JR: pc_write=1, pc_src=3.
- Every last state (MEMWB, MEMWRITE on ready, ALUWB, IWB, BRANCH, JUMP, JAL, JR) returns to FETCH and increments instr_retired, which wraps modulo 2^CNT_WIDTH.
- Latency with mem_ready always high: LW 5 cycles; SW/RTYPE/I-type 4; BEQ/J/JAL/JR 3.
- Wait counter: clears on entry to any memory state and counts while mem_req=1 and mem_ready=0. When MEM_TIMEOUT!=0 and the count reaches MEM_TIMEOUT -> TRAP cause 3. mem_ready in the same cycle as the limit wins.
- TRAP: all control 0, trap=1, cause held. Left only by rst; a mid-wait rst drops mem_req in the next cycle.

Decomposition:
- Put mips_ctrl_state_e (5-bit) and mips_ctrl_alu_op_e (ADD, SUB, FUNCT, SLT, SLTU, AND, OR, LUI) in MIPS_pkg, next to the existing op/funct enums.
- Sub-module mips_mem_wait_timer holds the wait counter and timeout compare.

Test Plan:
- ADDI then J, mem_ready tied 1 -> cycles 4+3, instr_retired=2, pc_src=2 in JUMP.
- LW with mem_ready delayed 3 cycles in MEMREAD -> mem_req held 4 cycles, total 8 cycles, reg_write only in MEMWB.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> trap=1, trap_cause=3 after 4 wait cycles; pc_write never pulses.
- op=6'h3F -> TRAP cause 1; RTYPE funct=6'h3F -> cause 2; EXT_ISA=0 with JAL -> cause 1.
- JAL -> reg_dst=2, mem_to_reg=2, pc_write=1 in the same cycle; JR -> pc_src=3; BNE -> branch_ne=1, branch_eq=0.
- rst asserted mid-MEMWRITE wait -> next cycle mem_req=0, state FETCH, counters 0.
